sdram_line_cache: RTL and testbench

- Direct-mapped read cache between a CPU/ROM fetch port and one 64-bit, 4-word-burst read channel of the SDRAM controller.
- Hits are served from on-chip line storage.
- Misses issue one burst request and refill the whole 4-word line.
- Used in front of ROM-fetch channels so repeated opcode/tile fetches do not occupy SDRAM bandwidth.

---
 rtl/sdram_line_cache_if.sv | 31 +++
 rtl/sdram_line_cache.sv | 204 ++++++++++++++++++++
 tb/tb_sdram_line_cache.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_line_cache_if.sv
// sdram_line_cache_if -- bus bundle between the fetch port, the line cache and
// one 64-bit burst read channel of the SDRAM controller.
//   cpu_addr/cpu_req/flush      : fetch side requests (word address [ADDR_HI:1])
//   cpu_dout/cpu_ready/cpu_busy : fetch side response
//   sdr_addr/sdr_req            : burst request towards the controller
//   sdr_din/sdr_ready           : burst data back from the controller
// master = fetch port + controller side, slave = the cache.
interface sdram_line_cache_if #(
  parameter int ADDR_HI = 26
);
  logic [ADDR_HI:1] cpu_addr;
  logic             cpu_req;
  logic [15:0]      cpu_dout;
  logic             cpu_ready;
  logic             cpu_busy;
  logic             flush;
  logic [ADDR_HI:1] sdr_addr;
  logic             sdr_req;
  logic [63:0]      sdr_din;
  logic             sdr_ready;

  modport master (
    output cpu_addr, cpu_req, flush, sdr_din, sdr_ready,
    input  cpu_dout, cpu_ready, cpu_busy, sdr_addr, sdr_req
  );

  modport slave (
    input  cpu_addr, cpu_req, flush, sdr_din, sdr_ready,
    output cpu_dout, cpu_ready, cpu_busy, sdr_addr, sdr_req
  );
endinterface

// File: rtl/sdram_line_cache.sv
// sdram_line_cache -- direct-mapped read cache of 2^IDX_W lines x 4 words x 16 bit
// in front of a 4-word-burst SDRAM read channel. Hits answer two cycles after the
// request strobe; misses fetch the whole line with one level request and answer
// with the requested word as the burst returns.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : sdram_line_cache_if.slave (fetch port + SDRAM burst channel)
// Optional (macro SDRAM_LINE_CACHE_STATS_EN):
//   stats_clr  : synchronous clear of both counters (wins over an increment)
//   hit_count, miss_count : saturating 32-bit lookup statistics
module sdram_line_cache #(
  parameter int IDX_W   = 6,
  parameter int ADDR_HI = 26
) (
  input  logic               clk,
  input  logic               reset,
  sdram_line_cache_if.slave  bus
`ifdef SDRAM_LINE_CACHE_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
`endif
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = ADDR_HI - IDX_W - 2;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FILL} state_t;

  state_t             state_q, state_d;
  logic [ADDR_HI:1]   addr_q, addr_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic [15:0]        dout_q, dout_d;
  logic               sdr_req_q, sdr_req_d;
  logic [ADDR_HI:1]   sdr_addr_q, sdr_addr_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic               flush_pend_q, flush_pend_d;

  logic [63:0]        data_ram [LINES];
  logic [TAG_W-1:0]   tag_ram  [LINES];
  logic [63:0]        rd_data_q;
  logic [TAG_W-1:0]   rd_tag_q;

  logic               accept;
  logic               ram_we;
  logic               lookup_hit;
  logic               lookup_miss;
  logic [IDX_W-1:0]   idx_q;
  logic [TAG_W-1:0]   tag_q;

  function automatic logic [15:0] word_sel(input logic [63:0] line, input logic [1:0] w);
    logic [15:0] r;
    unique case (w)
      2'd0:    r = line[15:0];
      2'd1:    r = line[31:16];
      2'd2:    r = line[47:32];
      default: r = line[63:48];
    endcase
    return r;
  endfunction

  assign idx_q  = addr_q[IDX_W+2:3];
  assign tag_q  = addr_q[ADDR_HI:IDX_W+3];
  assign accept = (state_q == S_IDLE) && bus.cpu_req && !busy_q;

  // A flush in the lookup cycle forces a miss so no stale line is returned.
  assign lookup_hit  = (state_q == S_LOOKUP) && valid_q[idx_q] &&
                       (rd_tag_q == tag_q) && !bus.flush;
  assign lookup_miss = (state_q == S_LOOKUP) && !lookup_hit;

  // Line storage: read registered at request acceptance so tag/data are ready
  // in LOOKUP; writes only happen in FILL, so read and write never collide.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      data_ram[idx_q] <= bus.sdr_din;
      tag_ram[idx_q]  <= tag_q;
    end
    if (accept) begin
      rd_data_q <= data_ram[bus.cpu_addr[IDX_W+2:3]];
      rd_tag_q  <= tag_ram[bus.cpu_addr[IDX_W+2:3]];
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    busy_d       = busy_q;
    ready_d      = 1'b0;
    dout_d       = dout_q;
    sdr_req_d    = sdr_req_q;
    sdr_addr_d   = sdr_addr_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    ram_we       = 1'b0;

    // busy covers the response cycle and drops right after it
    if (ready_q) busy_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.flush || flush_pend_q) begin
          valid_d      = '0;
          flush_pend_d = 1'b0;
        end
        if (accept) begin
          addr_d  = bus.cpu_addr;
          busy_d  = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (bus.flush) valid_d = '0;
        if (lookup_hit) begin
          dout_d  = word_sel(rd_data_q, addr_q[2:1]);
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          sdr_addr_d = {addr_q[ADDR_HI:3], 2'b00};
          sdr_req_d  = 1'b1;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        if (bus.sdr_ready) begin
          // a flush seen during the fill (including this cycle) leaves the new
          // line invalid and clears everything on the following cycle
          sdr_req_d      = 1'b0;
          ram_we         = 1'b1;
          valid_d[idx_q] = !(flush_pend_q || bus.flush);
          flush_pend_d   = flush_pend_q || bus.flush;
          dout_d         = word_sel(bus.sdr_din, addr_q[2:1]);
          ready_d        = 1'b1;
          state_d        = S_IDLE;
        end else if (bus.flush) begin
          flush_pend_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b0;
      dout_q       <= '0;
      sdr_req_q    <= 1'b0;
      sdr_addr_q   <= '0;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      dout_q       <= dout_d;
      sdr_req_q    <= sdr_req_d;
      sdr_addr_q   <= sdr_addr_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign bus.cpu_dout  = dout_q;
  assign bus.cpu_ready = ready_q;
  assign bus.cpu_busy  = busy_q;
  assign bus.sdr_req   = sdr_req_q;
  assign bus.sdr_addr  = sdr_addr_q;

`ifdef SDRAM_LINE_CACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (stats_clr) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else begin
      if (lookup_hit && (hit_cnt_q != '1))   hit_cnt_d  = hit_cnt_q + 32'd1;
      if (lookup_miss && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_sdram_line_cache.sv
// tb_sdram_line_cache -- directed + randomized bench for sdram_line_cache with a
// behavioural cache/memory model and a simple burst controller responder.
module tb_sdram_line_cache;
  localparam int IDX_W   = 6;
  localparam int ADDR_HI = 26;
  localparam int NLINES  = 1 << IDX_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sdram_line_cache_if #(.ADDR_HI(ADDR_HI)) bus ();

`ifdef SDRAM_LINE_CACHE_STATS_EN
  logic        stats_clr = 1'b0;
  logic [31:0] hit_count, miss_count;
`endif

  sdram_line_cache #(.IDX_W(IDX_W), .ADDR_HI(ADDR_HI)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef SDRAM_LINE_CACHE_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model: memory + direct-mapped line table
  logic [63:0] mem [int unsigned];
  bit          m_valid [NLINES];
  int unsigned m_tag   [NLINES];
  logic [63:0] m_data  [NLINES];

  function automatic logic [63:0] mem_line(input int unsigned line);
    if (!mem.exists(line)) mem[line] = {$urandom, $urandom};
    return mem[line];
  endfunction

  function automatic int unsigned m_idx(input int unsigned a);
    return (a / 4) % NLINES;
  endfunction

  function automatic int unsigned m_tagof(input int unsigned a);
    return a / (4 * NLINES);
  endfunction

  function automatic logic [15:0] m_word(input logic [63:0] l, input int unsigned a);
    return l[16*(a%4) +: 16];
  endfunction

  function automatic void m_flush_all();
    for (int i = 0; i < NLINES; i++) m_valid[i] = 1'b0;
  endfunction

  // ---------------- monitor: sdr_req rises, low gap, cpu_ready pulses
  int unsigned rises = 0;
  int unsigned ready_pulses = 0;
  int unsigned low_run = 0;
  int unsigned min_gap = 1000;
  logic        mon_prev = 1'b0;

  always begin
    @(posedge clk);
    #2;
    if (bus.sdr_req && !mon_prev) begin
      rises++;
      if (rises > 1 && low_run < min_gap) min_gap = low_run;
    end
    if (bus.sdr_req) low_run = 0;
    else low_run++;
    mon_prev = bus.sdr_req;
    if (bus.cpu_ready) ready_pulses++;
  end

  // ---------------- controller: answers each sdr_req rise after ctrl_lat cycles
  int unsigned ctrl_lat = 5;
  bit          ctrl_busy = 1'b0;
  logic        ctrl_prev = 1'b0;

  initial begin
    int unsigned line;
    bus.sdr_ready = 1'b0;
    bus.sdr_din   = '0;
    forever begin
      @(negedge clk);
      if (bus.sdr_req && !ctrl_prev) begin
        ctrl_busy = 1'b1;
        line = 32'(bus.sdr_addr) / 4;
        repeat (ctrl_lat) @(negedge clk);
        bus.sdr_din   = mem_line(line);
        bus.sdr_ready = 1'b1;
        @(negedge clk);
        bus.sdr_ready = 1'b0;
        bus.sdr_din   = {$urandom, $urandom};
        ctrl_busy = 1'b0;
      end
      ctrl_prev = bus.sdr_req;
    end
  end

  // One read transaction, entered and left on a falling edge.
  task automatic do_read(input int unsigned a, input bit flush_fill, input bit poke, input string tag);
    bit          hit, flushed;
    logic [15:0] exp;
    int unsigned r0, cyc, idx;
    idx = m_idx(a);
    hit = m_valid[idx] && (m_tag[idx] == m_tagof(a));
    exp = hit ? m_word(m_data[idx], a) : m_word(mem_line(a / 4), a);
    cyc = 0;
    while (bus.cpu_busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    r0 = rises;
    bus.cpu_addr = ADDR_HI'(a);
    bus.cpu_req  = 1'b1;
    cyc = 0;
    flushed = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      bus.cpu_req = 1'b0;
      bus.flush   = 1'b0;
      if (poke && cyc == 1) begin
        bus.cpu_addr = ADDR_HI'(a ^ 32'h100);
        bus.cpu_req  = 1'b1;
      end
      if (flush_fill && !flushed && bus.sdr_req) begin
        bus.flush = 1'b1;
        flushed   = 1'b1;
      end
    end while (!bus.cpu_ready && cyc < 60);
    bus.flush   = 1'b0;
    bus.cpu_req = 1'b0;
    chk({tag, "_ready"}, 64'(bus.cpu_ready), 64'd1);
    chk({tag, "_dout"}, 64'(bus.cpu_dout), 64'(exp));
    chk({tag, "_busy"}, 64'(bus.cpu_busy), 64'd1);
    chk({tag, "_rises"}, 64'(rises - r0), hit ? 64'd0 : 64'd1);
    if (hit) chk({tag, "_hit_lat"}, 64'(cyc), 64'd2);
    if (!hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = m_tagof(a);
      m_data[idx]  = mem_line(a / 4);
      if (flushed) m_flush_all();
    end
  endtask

  initial begin
    int unsigned r0, rp0, cyc, a, lines[$];
    reset        = 1'b1;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = '0;
    bus.flush    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", 64'(bus.cpu_dout), 64'd0);
    chk("rst_ready", 64'(bus.cpu_ready), 64'd0);
    chk("rst_busy", 64'(bus.cpu_busy), 64'd0);
    chk("rst_sdr_req", 64'(bus.sdr_req), 64'd0);
    chk("rst_sdr_addr", 64'(bus.sdr_addr), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // cold miss then hits within the same line
    mem[1] = 64'h4444_3333_2222_1111;
    ctrl_lat = 5;
    do_read(32'h6, 1'b0, 1'b0, "cold");
    chk("cold_sdr_addr", 64'(bus.sdr_addr), 64'h4);
    do_read(32'h4, 1'b0, 1'b0, "hit4");
    do_read(32'h5, 1'b0, 1'b0, "hit5");
    do_read(32'h7, 1'b0, 1'b0, "hit7");

    // flush while idle invalidates the line
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    m_flush_all();
    do_read(32'h4, 1'b0, 1'b0, "after_flush");

    // conflict eviction: refetch must pick up changed memory
    do_read(32'h204, 1'b0, 1'b0, "conflict");
    mem[1] = 64'hDDDD_CCCC_BBBB_AAAA;
    do_read(32'h4, 1'b0, 1'b0, "refetch");

    // flush during fill, then immediate re-read misses
    do_read(32'h300, 1'b1, 1'b0, "flush_fill");
    do_read(32'h300, 1'b0, 1'b0, "flush_reread");

    // request while busy is ignored
    do_read(32'h410, 1'b0, 1'b1, "busy_poke");

    // back-to-back misses
    ctrl_lat = 2;
    do_read(32'h520, 1'b0, 1'b0, "b2b_a");
    @(negedge clk);
    chk("b2b_busy_low", 64'(bus.cpu_busy), 64'd0);
    do_read(32'h645, 1'b0, 1'b0, "b2b_b");

    // reset in the middle of a fill, stray sdr_ready afterwards
    ctrl_lat = 8;
    @(negedge clk);
    @(negedge clk);
    bus.cpu_addr = ADDR_HI'(32'h7F0);
    bus.cpu_req  = 1'b1;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    cyc = 0;
    while (!bus.sdr_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_fill_entered", 64'(bus.sdr_req), 64'd1);
    @(negedge clk);
    rp0 = ready_pulses;
    reset = 1'b1;
    #1;
    chk("rst_fill_req_drop", 64'(bus.sdr_req), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    while (ctrl_busy && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    chk("rst_fill_ctrl_done", 64'(ctrl_busy), 64'd0);
    chk("rst_fill_no_ready", 64'(ready_pulses - rp0), 64'd0);
    m_flush_all();
    ctrl_lat = 3;
    do_read(32'h4, 1'b0, 1'b0, "post_rst_miss");

    // randomized reads over a few lines, some sharing an index
    lines = '{0, 1, 2, 3, 5, 64, 65, 129, 200, 264};
    for (int i = 0; i < 40; i++) begin
      a = lines[$urandom_range(0, lines.size() - 1)] * 4 + $urandom_range(0, 3);
      ctrl_lat = $urandom_range(1, 6);
      do_read(a, ($urandom % 8) == 0, ($urandom % 6) == 0, $sformatf("rnd%0d", i));
    end

    chk("req_low_gap_ge2", 64'(min_gap >= 2), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
